// File: rtl/uart_pkg.sv
// Shared constants for UART register-bus initiators: register map, status bits,
// reply bytes and the boot loader state encoding.
package uart_pkg;

  localparam logic [4:0] REG_RX   = 5'h00;
  localparam logic [4:0] REG_TX   = 5'h04;
  localparam logic [4:0] REG_STAT = 5'h08;
  localparam logic [4:0] REG_CTRL = 5'h0C;
  localparam logic [4:0] REG_DIVL = 5'h10;
  localparam logic [4:0] REG_DIVH = 5'h14;

  localparam int STAT_RX_NE    = 0;
  localparam int STAT_TX_FULL  = 3;
  localparam int STAT_OVERRUN  = 5;
  localparam int STAT_FRAME    = 6;

  localparam logic [7:0] ACK_BYTE = 8'h4B;
  localparam logic [7:0] NAK_BYTE = 8'h45;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CFG_LO,
    ST_CFG_HI,
    ST_POLL,
    ST_READ,
    ST_SETTLE,
    ST_MEM_WR,
    ST_ACK_POLL,
    ST_ACK_WR,
    ST_ERROR,
    ST_DONE,
    ST_FAIL
  } state_t;

  // Line errors reported by the status register; reading it clears them.
  function automatic logic rx_fault(input logic [7:0] stat);
    return stat[STAT_FRAME] | stat[STAT_OVERRUN];
  endfunction

endpackage

// File: rtl/uart_boot_loader_if.sv
// Bus bundle of the boot loader: UART register handshake plus memory write port.
interface uart_boot_loader_if #(
  parameter int ADDR_WIDTH = 32
);

  logic                  hs_read_o;
  logic                  hs_write_o;
  logic [4:0]            hs_addr_o;
  logic [7:0]            hs_data_o;
  logic                  hs_ready_i;
  logic [7:0]            hs_data_i;

  logic                  mem_write_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [31:0]           mem_data_o;
  logic                  mem_ready_i;

  modport master (
    output hs_read_o, hs_write_o, hs_addr_o, hs_data_o,
    input  hs_ready_i, hs_data_i,
    output mem_write_o, mem_addr_o, mem_data_o,
    input  mem_ready_i
  );

  modport slave (
    input  hs_read_o, hs_write_o, hs_addr_o, hs_data_o,
    output hs_ready_i, hs_data_i,
    input  mem_write_o, mem_addr_o, mem_data_o,
    output mem_ready_i
  );

endinterface

// File: rtl/hs_master_port.sv
// Single-outstanding handshake request holder: latches one read/write request,
// holds it until ready, then emits a one-cycle done pulse with captured read data.
module hs_master_port (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       issue_i,
  input  logic       we_i,
  input  logic [4:0] addr_i,
  input  logic [7:0] wdata_i,
  output logic       done_o,
  output logic [7:0] rdata_o,
  output logic       hs_read_o,
  output logic       hs_write_o,
  output logic [4:0] hs_addr_o,
  output logic [7:0] hs_data_o,
  input  logic       hs_ready_i,
  input  logic [7:0] hs_data_i
);

  logic active;

  assign active = hs_read_o | hs_write_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hs_read_o  <= 1'b0;
      hs_write_o <= 1'b0;
      hs_addr_o  <= '0;
      hs_data_o  <= '0;
      done_o     <= 1'b0;
      rdata_o    <= '0;
    end else begin
      done_o <= 1'b0;
      if (active && hs_ready_i) begin
        hs_read_o  <= 1'b0;
        hs_write_o <= 1'b0;
        done_o     <= 1'b1;
        if (hs_read_o) rdata_o <= hs_data_i;
      end else if (issue_i && !active) begin
        // New requests are only taken while idle, so at most one is ever open.
        hs_read_o  <= ~we_i;
        hs_write_o <= we_i;
        hs_addr_o  <= addr_i;
        hs_data_o  <= we_i ? wdata_i : 8'h00;
      end
    end
  end

endmodule

// File: rtl/uart_boot_loader.sv
// Boot loader: configures the UART, receives a length-prefixed image, writes it
// as little-endian words to memory and answers with 'K' or 'E'.
module uart_boot_loader
  import uart_pkg::*;
#(
  parameter logic [15:0]           CLK_DIV    = 16'd868,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter logic [31:0]           MAX_BYTES  = 32'd65536
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  output logic busy_o,
  output logic done_o,
  output logic error_o,
  uart_boot_loader_if.master bus
);

  state_t                state;
  logic                  issued;
  logic                  issue_q;
  logic                  settle_q;
  logic                  is_err;
  logic [31:0]           byte_cnt;
  logic [31:0]           len_q;
  logic [31:0]           word_q;
  logic [ADDR_WIDTH-3:0] word_idx;
  logic                  mem_write_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [31:0]           mem_data_q;

  logic                  hs_state;
  logic                  req_we;
  logic [4:0]            req_addr;
  logic [7:0]            req_wdata;
  logic                  port_done;
  logic [7:0]            port_rdata;
  logic                  hs_read, hs_write;
  logic [4:0]            hs_addr;
  logic [7:0]            hs_wdata;
  logic [4:0]            byte_sel;
  logic                  payload_done;

  assign byte_sel     = {byte_cnt[1:0], 3'b000};
  assign payload_done = (byte_cnt - 32'd4) == len_q;

  // Request contents follow the state; they are only sampled at issue time.
  always_comb begin
    hs_state  = 1'b1;
    req_we    = 1'b0;
    req_addr  = REG_STAT;
    req_wdata = 8'h00;
    case (state)
      ST_CFG_LO: begin
        req_we    = 1'b1;
        req_addr  = REG_DIVL;
        req_wdata = CLK_DIV[7:0];
      end
      ST_CFG_HI: begin
        req_we    = 1'b1;
        req_addr  = REG_DIVH;
        req_wdata = CLK_DIV[15:8];
      end
      ST_POLL, ST_ACK_POLL: ;
      ST_READ:   req_addr = REG_RX;
      ST_ACK_WR: begin
        req_we    = 1'b1;
        req_addr  = REG_TX;
        req_wdata = is_err ? NAK_BYTE : ACK_BYTE;
      end
      default:   hs_state = 1'b0;
    endcase
  end

  hs_master_port u_port (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .issue_i    (issue_q),
    .we_i       (req_we),
    .addr_i     (req_addr),
    .wdata_i    (req_wdata),
    .done_o     (port_done),
    .rdata_o    (port_rdata),
    .hs_read_o  (hs_read),
    .hs_write_o (hs_write),
    .hs_addr_o  (hs_addr),
    .hs_data_o  (hs_wdata),
    .hs_ready_i (bus.hs_ready_i),
    .hs_data_i  (bus.hs_data_i)
  );

  assign bus.hs_read_o   = hs_read;
  assign bus.hs_write_o  = hs_write;
  assign bus.hs_addr_o   = hs_addr;
  assign bus.hs_data_o   = hs_wdata;
  assign bus.mem_write_o = mem_write_q;
  assign bus.mem_addr_o  = mem_addr_q;
  assign bus.mem_data_o  = mem_data_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= ST_IDLE;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      error_o     <= 1'b0;
      issued      <= 1'b0;
      issue_q     <= 1'b0;
      settle_q    <= 1'b0;
      is_err      <= 1'b0;
      byte_cnt    <= '0;
      len_q       <= '0;
      word_q      <= '0;
      word_idx    <= '0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
    end else begin
      issue_q <= 1'b0;
      if (hs_state && !issued) begin
        issue_q <= 1'b1;
        issued  <= 1'b1;
      end

      case (state)
        ST_IDLE, ST_DONE, ST_FAIL: begin
          if (start_i) begin
            busy_o   <= 1'b1;
            done_o   <= 1'b0;
            error_o  <= 1'b0;
            is_err   <= 1'b0;
            byte_cnt <= '0;
            len_q    <= '0;
            word_q   <= '0;
            word_idx <= '0;
            state    <= ST_CFG_LO;
          end
        end

        ST_CFG_LO: if (port_done) begin
          issued <= 1'b0;
          state  <= ST_CFG_HI;
        end

        ST_CFG_HI: if (port_done) begin
          issued <= 1'b0;
          state  <= ST_POLL;
        end

        ST_POLL: if (port_done) begin
          issued <= 1'b0;
          if (rx_fault(port_rdata))          state <= ST_ERROR;
          else if (port_rdata[STAT_RX_NE])   state <= ST_READ;
        end

        // Header bytes fill the length; payload bytes land in lane byte_cnt%4.
        ST_READ: if (port_done) begin
          issued   <= 1'b0;
          byte_cnt <= byte_cnt + 32'd1;
          if (byte_cnt < 32'd4) len_q[byte_sel +: 8]  <= port_rdata;
          else                  word_q[byte_sel +: 8] <= port_rdata;
          settle_q <= 1'b0;
          state    <= ST_SETTLE;
        end

        ST_SETTLE: begin
          if (!settle_q) begin
            settle_q <= 1'b1;
          end else if (byte_cnt == 32'd4) begin
            if (len_q > MAX_BYTES)  state <= ST_ERROR;
            else if (len_q == '0)   state <= ST_ACK_POLL;
            else                    state <= ST_POLL;
          end else if (byte_cnt > 32'd4 && (byte_cnt[1:0] == 2'b00 || payload_done)) begin
            mem_write_q <= 1'b1;
            mem_addr_q  <= BASE_ADDR + {word_idx, 2'b00};
            mem_data_q  <= word_q;
            state       <= ST_MEM_WR;
          end else begin
            state <= ST_POLL;
          end
        end

        ST_MEM_WR: if (bus.mem_ready_i) begin
          mem_write_q <= 1'b0;
          word_idx    <= word_idx + (ADDR_WIDTH-2)'(1);
          word_q      <= '0;
          state       <= payload_done ? ST_ACK_POLL : ST_POLL;
        end

        ST_ACK_POLL: if (port_done) begin
          issued <= 1'b0;
          if (!port_rdata[STAT_TX_FULL]) state <= ST_ACK_WR;
        end

        ST_ACK_WR: if (port_done) begin
          issued <= 1'b0;
          busy_o <= 1'b0;
          if (is_err) begin
            state <= ST_FAIL;
          end else begin
            done_o <= 1'b1;
            state  <= ST_DONE;
          end
        end

        ST_ERROR: begin
          error_o <= 1'b1;
          is_err  <= 1'b1;
          state   <= ST_ACK_POLL;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
